path_job_sequencer: RTL and testbench
=====================================

PATH_JOB_SEQUENCER -- requirements
Module: path_job_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD, default 4: cycles cpu_rst is held high per job (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: RUN-state cycle limit (legal range 2..2^24-1; only used under PATH_TIMEOUT_EN).
REQ-003 clk_50M  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  job request present.
REQ-006 req_ready  output  1  sequencer accepts a job.
REQ-007 req_sp  input  5  start point of job.
REQ-008 req_ep  input  5  end point of job.
REQ-009 cpu_rst  output  1  reset to path-planning CPU, active-high.
REQ-010 cpu_sp  output  5  SP driven to CPU.
REQ-011 cpu_ep  output  5  EP driven to CPU.
REQ-012 cpu_path_found  input  1  CPU completion flag.
REQ-013 cpu_path_flat  input  288  CPU path0..path8; path0 = bits [31:0], pathN = bits [32N+31:32N].
REQ-014 resp_valid  output  1  result word valid.
REQ-015 resp_ready  input  1  consumer accepts word.
REQ-016 resp_word  output  32  captured path word.
REQ-017 resp_idx  output  4  word index 0..8.
REQ-018 resp_last  output  1  high with resp_idx==8.
REQ-019 resp_timeout  output  1  job ended by timeout; constant across all nine words of that job.

Function
REQ-020 States SHALL be IDLE, LOAD, RUN, CAPTURE, SEND.
REQ-021 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; on handshake req_sp/req_ep SHALL latch into cpu_sp/cpu_ep, state -> LOAD.
REQ-022 cpu_sp/cpu_ep SHALL hold their latched value from handshake until the next handshake.
REQ-023 LOAD SHALL assert cpu_rst for exactly RST_HOLD cycles, then -> RUN with cpu_rst low.
REQ-024 cpu_rst SHALL be high in IDLE and LOAD, low in RUN, CAPTURE, SEND.
REQ-025 RUN SHALL ignore cpu_path_found during the first cycle after LOAD (CPU settle); from the second RUN cycle, cpu_path_found==1 -> CAPTURE.
REQ-026 CAPTURE SHALL last one cycle, registering all nine words of cpu_path_flat into an internal 9x32 buffer, then -> SEND with resp_idx=0.
REQ-027 SEND SHALL drive resp_valid=1, resp_word=buffer[resp_idx]; on resp_valid & resp_ready resp_idx SHALL increment; handshake at idx 8 -> IDLE, resp_valid low next cycle.
REQ-028 While resp_valid & !resp_ready, resp_word/resp_idx/resp_last SHALL remain stable.
REQ-029 Back-to-back: with resp_ready held high, nine words SHALL emit on nine consecutive cycles; req_ready SHALL rise the cycle after the last handshake.
REQ-030 Job latency SHALL be: handshake -> RST_HOLD LOAD cycles -> RUN cycles -> 1 CAPTURE cycle -> first resp_valid.
REQ-031 cpu_path_found changes outside RUN SHALL have no effect.

Reset
REQ-032 rst SHALL take effect at the next clk_50M edge, from any state, including mid-LOAD, mid-RUN, mid-SEND, aborting the job with no response.
REQ-033 Reset values: state IDLE, req_ready 1 (first cycle after reset), cpu_rst 1, cpu_sp 0, cpu_ep 0, resp_valid 0, resp_word 0, resp_idx 0, resp_last 0, resp_timeout 0, timeout counter 0, buffer 0.

Configuration
REQ-034 Macro PATH_TIMEOUT_EN SHALL include a 24-bit RUN-cycle counter, cleared on RUN entry.
REQ-035 With PATH_TIMEOUT_EN: counter reaching TIMEOUT_CYCLES without cpu_path_found SHALL -> CAPTURE, resp_timeout=1, buffer words all 0; cpu_path_found at the same cycle SHALL win (normal capture, resp_timeout=0).
REQ-036 Without PATH_TIMEOUT_EN: RUN SHALL wait indefinitely; resp_timeout SHALL be constant 0; no counter logic SHALL be present.

Verification
REQ-037 Reset, then req sp=8 ep=17; CPU model raises path_found 20 cycles into RUN with path0=0x00000811 -> cpu_sp=8, cpu_ep=17, cpu_rst high 4 cycles, words idx0..8 out, idx0 word 0x00000811, resp_last at idx 8.
REQ-038 resp_ready toggled 1/0 each cycle during SEND -> all nine words delivered in order, outputs stable while stalled, 17 SEND cycles.
REQ-039 path_found held high before and during LOAD and in first RUN cycle -> CAPTURE occurs exactly in second RUN cycle.
REQ-040 rst pulsed for one cycle at resp_idx=4 -> resp_valid 0 next cycle, req_ready 1, cpu_sp 0, cpu_ep 0.
REQ-041 PATH_TIMEOUT_EN, TIMEOUT_CYCLES=50, path_found never raised -> after 50 RUN cycles nine zero words with resp_timeout=1; path_found asserted at cycle 50 -> resp_timeout=0.
REQ-042 req_valid held high continuously across two jobs -> second handshake occurs only in the cycle after first job's idx-8 handshake.

Source files
------------

// File: rtl/path_job_sequencer.sv
// Path-planning job sequencer: accept SP/EP, pulse CPU reset, wait for result, stream nine path words.
// Optional RUN-state watchdog enabled by defining PATH_TIMEOUT_EN.
module path_job_sequencer #(
  parameter int unsigned RST_HOLD       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk_50M,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [4:0]   req_sp,
  input  logic [4:0]   req_ep,
  output logic         cpu_rst,
  output logic [4:0]   cpu_sp,
  output logic [4:0]   cpu_ep,
  input  logic         cpu_path_found,
  input  logic [287:0] cpu_path_flat,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [31:0]  resp_word,
  output logic [3:0]   resp_idx,
  output logic         resp_last,
  output logic         resp_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_SEND
  } state_t;

  localparam logic [3:0] LOAD_LAST = 4'(RST_HOLD - 1);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [4:0]  cpu_sp_q, cpu_sp_d;
  logic [4:0]  cpu_ep_q, cpu_ep_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_word_q, resp_word_d;
  logic [3:0]  resp_idx_q, resp_idx_d;
  logic        resp_last_q, resp_last_d;
  logic        resp_timeout_q, resp_timeout_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic        run_first_q, run_first_d;
  logic [31:0] path_buf_q [9];
  logic [31:0] path_buf_d [9];
  logic [3:0]  idx_nxt;

`ifdef PATH_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
`else
  // Watchdog limit has no meaning in this build.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign idx_nxt = resp_idx_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    cpu_rst_d      = cpu_rst_q;
    cpu_sp_d       = cpu_sp_q;
    cpu_ep_d       = cpu_ep_q;
    resp_valid_d   = resp_valid_q;
    resp_word_d    = resp_word_q;
    resp_idx_d     = resp_idx_q;
    resp_last_d    = resp_last_q;
    resp_timeout_d = resp_timeout_q;
    load_cnt_d     = load_cnt_q;
    run_first_d    = run_first_q;
    path_buf_d     = path_buf_q;
`ifdef PATH_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = ST_LOAD;
          req_ready_d = 1'b0;
          cpu_sp_d    = req_sp;
          cpu_ep_d    = req_ep;
          load_cnt_d  = 4'd0;
        end
      end

      ST_LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d     = ST_RUN;
          cpu_rst_d   = 1'b0;
          run_first_d = 1'b1;
`ifdef PATH_TIMEOUT_EN
          tmo_cnt_d   = 24'd0;
`endif
        end else begin
          load_cnt_d = load_cnt_q + 4'd1;
        end
      end

      // First RUN cycle is a settle cycle for the freshly released CPU.
      ST_RUN: begin
        run_first_d = 1'b0;
`ifdef PATH_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q + 24'd1;
`endif
        if (!run_first_q && cpu_path_found) begin
          state_d        = ST_CAPTURE;
          resp_timeout_d = 1'b0;
        end
`ifdef PATH_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d        = ST_CAPTURE;
          resp_timeout_d = 1'b1;
        end
`endif
      end

      ST_CAPTURE: begin
        for (int i = 0; i < 9; i++) begin
          path_buf_d[i] = resp_timeout_q ? 32'd0 : cpu_path_flat[32*i +: 32];
        end
        state_d      = ST_SEND;
        resp_valid_d = 1'b1;
        resp_idx_d   = 4'd0;
        resp_last_d  = 1'b0;
        resp_word_d  = resp_timeout_q ? 32'd0 : cpu_path_flat[31:0];
      end

      ST_SEND: begin
        if (resp_ready) begin
          if (resp_last_q) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
            resp_last_d  = 1'b0;
            resp_idx_d   = 4'd0;
            req_ready_d  = 1'b1;
            cpu_rst_d    = 1'b1;
          end else begin
            resp_idx_d  = idx_nxt;
            resp_word_d = path_buf_q[idx_nxt];
            resp_last_d = (idx_nxt == 4'd8);
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        cpu_rst_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b1;
      cpu_rst_q      <= 1'b1;
      cpu_sp_q       <= 5'd0;
      cpu_ep_q       <= 5'd0;
      resp_valid_q   <= 1'b0;
      resp_word_q    <= 32'd0;
      resp_idx_q     <= 4'd0;
      resp_last_q    <= 1'b0;
      resp_timeout_q <= 1'b0;
      load_cnt_q     <= 4'd0;
      run_first_q    <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        path_buf_q[i] <= 32'd0;
      end
`ifdef PATH_TIMEOUT_EN
      tmo_cnt_q      <= 24'd0;
`endif
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      cpu_rst_q      <= cpu_rst_d;
      cpu_sp_q       <= cpu_sp_d;
      cpu_ep_q       <= cpu_ep_d;
      resp_valid_q   <= resp_valid_d;
      resp_word_q    <= resp_word_d;
      resp_idx_q     <= resp_idx_d;
      resp_last_q    <= resp_last_d;
      resp_timeout_q <= resp_timeout_d;
      load_cnt_q     <= load_cnt_d;
      run_first_q    <= run_first_d;
      path_buf_q     <= path_buf_d;
`ifdef PATH_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign cpu_rst      = cpu_rst_q;
  assign cpu_sp       = cpu_sp_q;
  assign cpu_ep       = cpu_ep_q;
  assign resp_valid   = resp_valid_q;
  assign resp_word    = resp_word_q;
  assign resp_idx     = resp_idx_q;
  assign resp_last    = resp_last_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_path_job_sequencer.sv
// Directed + randomized bench for path_job_sequencer; timeout scenarios run when PATH_TIMEOUT_EN is defined.
module tb_path_job_sequencer;

  localparam int RST_HOLD = 4;
  localparam int TMO      = 50;

  logic         clk_50M = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [4:0]   req_sp;
  logic [4:0]   req_ep;
  logic         cpu_rst;
  logic [4:0]   cpu_sp;
  logic [4:0]   cpu_ep;
  logic         cpu_path_found;
  logic [287:0] cpu_path_flat;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_word;
  logic [3:0]   resp_idx;
  logic         resp_last;
  logic         resp_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] paths [9];

  always #10 clk_50M = ~clk_50M;

  path_job_sequencer #(.RST_HOLD(RST_HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50M        (clk_50M),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_sp         (req_sp),
    .req_ep         (req_ep),
    .cpu_rst        (cpu_rst),
    .cpu_sp         (cpu_sp),
    .cpu_ep         (cpu_ep),
    .cpu_path_found (cpu_path_found),
    .cpu_path_flat  (cpu_path_flat),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_word      (resp_word),
    .resp_idx       (resp_idx),
    .resp_last      (resp_last),
    .resp_timeout   (resp_timeout)
  );

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: number of RUN cycles spent before CAPTURE, given the RUN cycle (1-based)
  // at which the CPU raises path_found (0 = never).
  function automatic int exp_run_cycles(input int fd);
`ifdef PATH_TIMEOUT_EN
    if (fd == 0 || fd > TMO) return TMO;
`endif
    return (fd < 2) ? 2 : fd;
  endfunction

  function automatic bit exp_timeout(input int fd);
`ifdef PATH_TIMEOUT_EN
    return (fd == 0 || fd > TMO);
`else
    return (fd < 0);
`endif
  endfunction

  // load_mode: 0 found low in LOAD, 1 found high from before the request, 2 random.
  // rdy_mode: 0 always ready, 1 toggle 1/0, 2 random. abort_idx: word index to reset at (-1 none).
  task automatic run_job(input logic [4:0] sp, input logic [4:0] ep, input logic [31:0] p0,
                         input int fd, input int load_mode, input int rdy_mode,
                         input bit keep_valid, input int abort_idx, input bit chained);
    int n;
    int idx;
    int send_cyc;
    int exp_k;
    bit exp_tmo;
    bit rdy;
    logic [31:0] exp_w [9];

    for (int i = 0; i < 9; i++) paths[i] = $urandom;
    paths[0] = p0;
    for (int i = 0; i < 9; i++) cpu_path_flat[32*i +: 32] = paths[i];
    exp_k   = exp_run_cycles(fd);
    exp_tmo = exp_timeout(fd);
    for (int i = 0; i < 9; i++) exp_w[i] = exp_tmo ? 32'd0 : paths[i];

    req_sp = sp;
    req_ep = ep;
    req_valid = 1'b1;
    cpu_path_found = (load_mode == 1);
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (chained) chk("chain_wait", n, 0);
    if (req_ready !== 1'b1) begin
      chk("req_ready_wait", 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    step();
    if (!keep_valid) req_valid = 1'b0;
    req_sp = 5'($urandom);
    req_ep = 5'($urandom);
    chk("cpu_sp", 32'(cpu_sp), 32'(sp));
    chk("cpu_ep", 32'(cpu_ep), 32'(ep));

    n = 0;
    while (cpu_rst === 1'b1 && n < 40) begin
      if (load_mode == 2) cpu_path_found = 1'($urandom);
      step();
      n++;
    end
    chk("load_cycles", n, RST_HOLD);

    n = 0;
    while (resp_valid !== 1'b1 && n < 300) begin
      cpu_path_found = (fd != 0 && (n + 1) >= fd);
      step();
      n++;
    end
    chk("run_to_valid", n, exp_k + 1);
    chk("cpu_rst_send", 32'(cpu_rst), 0);

    idx = 0;
    send_cyc = 0;
    while (idx < 9 && send_cyc < 100) begin
      chk("resp_valid", 32'(resp_valid), 1);
      chk("resp_idx", 32'(resp_idx), idx);
      chk("resp_word", resp_word, exp_w[idx]);
      chk("resp_last", 32'(resp_last), 32'(idx == 8));
      chk("resp_timeout", 32'(resp_timeout), 32'(exp_tmo));
      if (idx == abort_idx) begin
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        resp_ready = 1'b0;
        chk("abort_valid", 32'(resp_valid), 0);
        chk("abort_req_ready", 32'(req_ready), 1);
        chk("abort_sp", 32'(cpu_sp), 0);
        chk("abort_ep", 32'(cpu_ep), 0);
        chk("abort_cpu_rst", 32'(cpu_rst), 1);
        chk("abort_idx", 32'(resp_idx), 0);
        return;
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (send_cyc % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      resp_ready = rdy;
      cpu_path_found = 1'($urandom);
      step();
      send_cyc++;
      if (rdy) idx++;
    end
    resp_ready = 1'b0;
    cpu_path_found = 1'b0;
    if (rdy_mode < 2) chk("send_cycles", send_cyc, (rdy_mode == 1) ? 17 : 9);
    chk("idle_valid", 32'(resp_valid), 0);
    chk("idle_req_ready", 32'(req_ready), 1);
    chk("idle_cpu_rst", 32'(cpu_rst), 1);
    chk("hold_sp", 32'(cpu_sp), 32'(sp));
    chk("hold_ep", 32'(cpu_ep), 32'(ep));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_sp = 5'd0;
    req_ep = 5'd0;
    cpu_path_found = 1'b0;
    cpu_path_flat = '0;
    resp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_cpu_sp", 32'(cpu_sp), 0);
    chk("rst_cpu_ep", 32'(cpu_ep), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_word", resp_word, 0);
    chk("rst_resp_idx", 32'(resp_idx), 0);
    chk("rst_resp_last", 32'(resp_last), 0);
    chk("rst_resp_timeout", 32'(resp_timeout), 0);
    rst = 1'b0;
    step();

    // Basic job, found 20 cycles into RUN.
    run_job(5'd8, 5'd17, 32'h0000_0811, 20, 0, 0, 1'b0, -1, 1'b0);
    // Consumer toggling ready every cycle.
    run_job(5'($urandom), 5'($urandom), $urandom, 10, 2, 1, 1'b0, -1, 1'b0);
    // found held high from before LOAD: capture after the second RUN cycle.
    run_job(5'd3, 5'd29, $urandom, 1, 1, 0, 1'b0, -1, 1'b0);
    // Reset mid-SEND at index 4.
    run_job(5'd21, 5'd6, $urandom, 7, 0, 0, 1'b0, 4, 1'b0);
    step();
    // req_valid held high across two jobs.
    run_job(5'd1, 5'd2, $urandom, 5, 0, 0, 1'b1, -1, 1'b0);
    run_job(5'd30, 5'd31, $urandom, 3, 0, 0, 1'b0, -1, 1'b1);
`ifdef PATH_TIMEOUT_EN
    run_job(5'd9, 5'd10, $urandom, 0, 0, 0, 1'b0, -1, 1'b0);
    run_job(5'd11, 5'd12, $urandom, TMO, 0, 1, 1'b0, -1, 1'b0);
    run_job(5'd13, 5'd14, $urandom, TMO + 1, 2, 2, 1'b0, -1, 1'b0);
`else
    run_job(5'd9, 5'd10, $urandom, 70, 0, 0, 1'b0, -1, 1'b0);
`endif
    for (int j = 0; j < 6; j++) begin
      run_job(5'($urandom), 5'($urandom), $urandom, int'($urandom_range(1, 45)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
